// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache each cycle and
// queues {pc, word} pairs for decode through a valid/ready FIFO.
module fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] ic_addr,
    output logic        ic_read_en,
    input  logic [31:0] ic_data,
    input  logic        ic_stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(QUEUE_DEPTH);

    logic [63:0]      pc_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             out_valid_r;
    logic [31:0]      instr_q_r [QUEUE_DEPTH];
    logic [63:0]      pc_q_r    [QUEUE_DEPTH];

    logic             pop_s;
    logic             room_s;
    logic             read_en_s;
    logic             push_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [63:0]      redirect_base_s;

    // Handshake decode: pop, room (a full queue may refill on a pop cycle), push.
    always_comb begin
        pop_s           = out_valid_r && out_ready;
        room_s          = (count_r < CNT_DEPTH) || pop_s;
        read_en_s       = reset_n && !redirect_valid && room_s;
        push_s          = read_en_s && !ic_stall;
        redirect_base_s = redirect_pc & ~64'h3;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // PC, queue pointers and occupancy; a redirect flushes and wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r        <= RESET_PC;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r        <= redirect_base_s;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                pc_r     <= pc_r + 64'd4;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // Queue storage; cleared on reset so the head reads as zero until filled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_q_r[i] <= 32'h0;
                pc_q_r[i]    <= 64'h0;
            end
        end else if (push_s) begin
            instr_q_r[wr_ptr_r] <= ic_data;
            pc_q_r[wr_ptr_r]    <= pc_r;
        end
    end

    assign ic_addr    = pc_r;
    assign ic_read_en = read_en_s;
    assign out_valid  = out_valid_r;
    assign out_instr  = instr_q_r[rd_ptr_r];
    assign out_pc     = pc_q_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, full-queue
// streaming, cache stall, redirect flush, PC wrap and asynchronous reset.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] ic_addr;
    logic        ic_read_en;
    logic [31:0] ic_data;
    logic        ic_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    int n_push;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ic_addr        (ic_addr),
        .ic_read_en     (ic_read_en),
        .ic_data        (ic_data),
        .ic_stall       (ic_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    // Cache model: word is a fixed function of the address, same cycle.
    function automatic logic [31:0] cache_word(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    assign ic_data = cache_word(ic_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        out_ready      = 1'b1;
        ic_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr",  ic_addr, RST_PC);
        check("rst_ren",   64'(ic_read_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pc",    out_pc, 64'd0);

        // Sequential fetch with decode always ready
        reset_n = 1'b1;
        #1;
        check("t1_ren",    64'(ic_read_en), 64'd1);
        check("t1_valid0", 64'(out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("t1_addr", ic_addr, RST_PC + 64'(4 * k));
            step();
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_pc",    out_pc, RST_PC + 64'(4 * k));
            check("t1_instr", 64'(out_instr), 64'(cache_word(RST_PC + 64'(4 * k))));
        end

        // Restart from reset with decode blocked: queue fills after four pushes
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("t2_rst_valid", 64'(out_valid), 64'd0);
        check("t2_rst_addr",  ic_addr, RST_PC);
        reset_n = 1'b1;
        #1;
        n_push = 0;
        for (int i = 0; i < 6; i++) begin
            if (ic_read_en) n_push++;
            step();
        end
        check("t2_pushes", 64'(n_push), 64'd4);
        check("t2_ren",    64'(ic_read_en), 64'd0);
        check("t2_addr",   ic_addr, 64'h1010);
        check("t2_head",   out_pc, 64'h1000);
        check("t2_valid",  64'(out_valid), 64'd1);

        // Full queue streaming: push and pop every cycle, strict order, no bubble
        out_ready = 1'b1;
        #1;
        check("t3_ren", 64'(ic_read_en), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("t3_valid", 64'(out_valid), 64'd1);
            check("t3_pc",    out_pc, 64'h1000 + 64'(4 * k));
            check("t3_addr",  ic_addr, 64'h1010 + 64'(4 * k));
            step();
        end
        out_ready = 1'b0;
        #1;
        check("t3_full", 64'(ic_read_en), 64'd0);
        out_ready = 1'b1;

        // Cache stall: no pushes, address held, queue drains
        ic_stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_addr", ic_addr, 64'h1020);
            check("t4_pc",   out_pc, 64'h1014 + 64'(4 * k));
        end
        ic_stall = 1'b0;
        step();
        check("t4_resume_pc",    out_pc, 64'h1020);
        check("t4_resume_instr", 64'(out_instr), 64'(cache_word(64'h1020)));
        check("t4_resume_addr",  ic_addr, 64'h1024);

        // Redirect with three entries queued
        out_ready = 1'b0;
        step();
        step();
        check("t5_head", out_pc, 64'h1020);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        out_ready      = 1'b1;
        #1;
        check("t5_ren", 64'(ic_read_en), 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_addr",  ic_addr, 64'h2000);
        step();
        check("t5_pc",     out_pc, 64'h2000);
        check("t5_valid1", 64'(out_valid), 64'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        check("t6_top_addr", ic_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("t6_wrap_addr", ic_addr, 64'h0);
        check("t6_wrap_pc",   out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Asynchronous reset mid-stream
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_addr",  ic_addr, RST_PC);
        check("t6_rst_ren",   64'(ic_read_en), 64'd0);
        check("t6_rst_pc",    out_pc, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        check("t6_restart", ic_addr, RST_PC + 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
